centroid_marker_overlay: RTL and testbench
==========================================

// Module: centroid_marker_overlay
// PURPOSE
//  Video-pipeline overlay stage placed after the centroid calculator. It draws a marker centred
//  on the detected object: a filled disc, a ring or a disc+crosshair, in a programmable colour,
//  over the RGB stream. Centroid and radius are captured once per frame, so the marker never
//  tears mid-frame. Pixel data and syncs leave with a fixed latency, aligned to each other.
// PARAMETERS
//  IMG_W       64   active pixels per line
//  IMG_H       64   active lines per frame
//  MAX_RADIUS  31   upper clamp for the radius input, in pixels
//  RING_W      2    ring thickness in pixels (mode RING)
//  LATENCY     3    pipeline depth; fixed at 3, not to be overridden
// PORTS
//  clk          in   1   pixel clock
//  rst          in   1   asynchronous, active-high reset
//  de           in   1   data enable
//  hsync        in   1   horizontal sync
//  vsync        in   1   vertical sync
//  pixel_in     in   24  RGB 8:8:8
//  x            in   12  centroid column (0-based)
//  y            in   12  centroid row (0-based)
//  c_valid      in   1   centroid valid (object detected)
//  radius       in   6   marker radius
//  mode         in   2   0=OFF 1=DISC 2=RING 3=DISC_CROSS
//  color        in   24  marker RGB
//  pixel_out    out  24  RGB out
//  de_out       out  1   de delayed by LATENCY
//  hsync_out    out  1   hsync delayed by LATENCY
//  vsync_out    out  1   vsync delayed by LATENCY
// BEHAVIOUR
//  - Reset: pixel_out=0, de_out=hsync_out=vsync_out=0, pos_x=pos_y=0, shadow_valid=0, pipeline cleared.
//  - Position: pos_x increments on each de=1 cycle and saturates at IMG_W-1. On de falling edge:
//    pos_x:=0, pos_y:=pos_y+1, saturating at IMG_H-1. On vsync rising edge: pos_x:=pos_y:=0.
//  - Frame capture: on vsync rising edge, latch x, y, c_valid, min(radius,MAX_RADIUS) and mode into
//    shadow registers. All drawing uses the shadow registers only. Input changes mid-frame take
//    effect in the next frame.
//  - Arithmetic: dx=pos_x-cx and dy=pos_y-cy are signed 13-bit. Squares are 26-bit unsigned;
//    d2=dx^2+dy^2 is 27-bit; r2=r*r is 12-bit. No truncation at any stage.
//  - Hit rules: DISC: d2<=r2.
//    RING: ri2<=d2<=r2 with ri=r-RING_W; when r<RING_W, ri=0 and RING behaves as DISC.
//    DISC_CROSS: DISC or pos_x==cx or pos_y==cy.
//    OFF, or shadow_valid=0: no hit.
//  - Output: pixel_out = hit&de ? color : pixel_in. The marker is clipped by the active area only;
//    a centroid at an edge or corner draws a partial disc. With r=0 and DISC, only the centre pixel
//    is painted.
//  - Pipeline: S1 registers pixel, syncs, position and dx/dy. S2 registers dx^2 and dy^2.
//    S3 registers compare/mux -> outputs. Latency is exactly 3 clocks for pixel, de, hsync and
//    vsync. No back-pressure, one pixel per clock.
//  - Simultaneous vsync rise and de=1: the counter reset wins, and that pixel is position (0,0).
//  - Reset mid-frame: outputs go to 0 immediately. No marker is drawn until the first vsync
//    rising edge after reset release, because shadow_valid=0 until then.
// STRUCTURE
//  - centroid_pkg.vh: MODE_OFF/DISC/RING/DISC_CROSS codes, COORD_W=12, RGB_W=24, PIPE_LAT=3.
//  - Sub-module dist2_unit: registered signed subtract and square for one axis, 2 stages.
//    Instantiated twice (x and y).
//  - Top level holds the position counters, edge detectors, shadow registers, hit logic and the
//    sync delay line.
// TESTING
//  1. 64x64, c=(32,32), r=5, DISC, color=FF0000 -> (32,27),(37,32) red; (36,36) (d2=32) and
//     (38,32) pass pixel_in unchanged.
//  2. RING, r=6, RING_W=2 -> (32,26) and (36,32) red; (32,32) and (33,32) pass; (32,25) passes.
//  3. DISC_CROSS, c=(0,63), r=3 -> whole row 63 and whole column 0 red; quarter disc only;
//     no wrap-around artefacts at x=63 or y=0.
//  4. Change x 10->40 mid-frame -> current frame marker stays at 10; next frame marker at 40.
//     c_valid=0 -> output == input, delayed 3.
//  5. Random stream with mode=OFF -> pixel_out, de_out, hsync_out and vsync_out equal inputs
//     delayed exactly 3 clocks, bit-exact.
//  6. Assert rst at line 20 of a frame -> all outputs 0 within the same cycle; after release, no
//     marker until the next vsync rise; radius=50 is clamped to 31.

Source files
------------

// File: rtl/centroid_marker_overlay_pkg.sv
// -----------------------------------------------------------------------------
// centroid_marker_overlay_pkg
//   Shared definitions for the centroid marker overlay:
//   - coordinate, colour and radius widths
//   - arithmetic widths for the squared-distance datapath
//   - marker mode codes
//   - per-frame marker configuration record
//   - radius clamp helper
// -----------------------------------------------------------------------------
package centroid_marker_overlay_pkg;

    localparam int unsigned COORD_W  = 12;
    localparam int unsigned RGB_W    = 24;
    localparam int unsigned RAD_W    = 6;
    localparam int unsigned PIPE_LAT = 3;

    // Signed axis difference is COORD_W+1 bits, its square twice that,
    // and the sum of two squares needs one more bit.
    localparam int unsigned DIFF_W = COORD_W + 1;
    localparam int unsigned SQ_W   = 2 * DIFF_W;
    localparam int unsigned D2_W   = SQ_W + 1;
    localparam int unsigned R2_W   = 2 * RAD_W;

    typedef enum logic [1:0] {
        MODE_OFF        = 2'd0,
        MODE_DISC       = 2'd1,
        MODE_RING       = 2'd2,
        MODE_DISC_CROSS = 2'd3
    } mode_e;

    // Marker settings frozen at the start of a frame.
    typedef struct packed {
        logic             valid;
        mode_e            mode;
        logic [RAD_W-1:0] r;
    } marker_cfg_t;

    function automatic logic [RAD_W-1:0] clamp_radius(
        input logic [RAD_W-1:0] r,
        input logic [RAD_W-1:0] max_r
    );
        return (r > max_r) ? max_r : r;
    endfunction

endpackage

// File: rtl/centroid_marker_overlay_if.sv
// -----------------------------------------------------------------------------
// centroid_marker_overlay_if
//   Video stream + centroid control bundle for the marker overlay.
//   master: video source / controller (drives stream in and marker settings,
//           observes the overlaid stream)
//   slave : the overlay stage
//   Signals: de, hsync, vsync, pixel_in, x, y, c_valid, radius, mode, color
//            (to overlay); pixel_out, de_out, hsync_out, vsync_out (from it).
// -----------------------------------------------------------------------------
interface centroid_marker_overlay_if;
    import centroid_marker_overlay_pkg::*;

    logic               de;
    logic               hsync;
    logic               vsync;
    logic [RGB_W-1:0]   pixel_in;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               c_valid;
    logic [RAD_W-1:0]   radius;
    logic [1:0]         mode;
    logic [RGB_W-1:0]   color;

    logic [RGB_W-1:0]   pixel_out;
    logic               de_out;
    logic               hsync_out;
    logic               vsync_out;

    modport master (
        output de, hsync, vsync, pixel_in, x, y, c_valid, radius, mode, color,
        input  pixel_out, de_out, hsync_out, vsync_out
    );

    modport slave (
        input  de, hsync, vsync, pixel_in, x, y, c_valid, radius, mode, color,
        output pixel_out, de_out, hsync_out, vsync_out
    );

endinterface

// File: rtl/centroid_marker_overlay_dist2_unit.sv
// -----------------------------------------------------------------------------
// dist2_unit
//   One axis of the squared-distance datapath, two register stages.
//   Stage 1: d_o  = pos_i - c_i   (signed, COORD_W+1 bits)
//   Stage 2: sq_o = d_o * d_o     (unsigned, 2*(COORD_W+1) bits)
//   Ports: clk, rst (async, active high), pos_i, c_i, d_o, sq_o.
// -----------------------------------------------------------------------------
module dist2_unit
    import centroid_marker_overlay_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [COORD_W-1:0]        pos_i,
    input  logic [COORD_W-1:0]        c_i,
    output logic signed [DIFF_W-1:0]  d_o,
    output logic [SQ_W-1:0]           sq_o
);

    logic signed [DIFF_W-1:0] d_d, d_q;
    logic signed [SQ_W-1:0]   d_ext;
    logic [SQ_W-1:0]          sq_d, sq_q;

    assign d_d   = $signed({1'b0, pos_i}) - $signed({1'b0, c_i});
    // Sign-extend before multiplying so the full square is kept.
    assign d_ext = SQ_W'(d_q);
    assign sq_d  = $unsigned(d_ext * d_ext);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q  <= '0;
            sq_q <= '0;
        end else begin
            d_q  <= d_d;
            sq_q <= sq_d;
        end
    end

    assign d_o  = d_q;
    assign sq_o = sq_q;

endmodule

// File: rtl/centroid_marker_overlay.sv
// -----------------------------------------------------------------------------
// centroid_marker_overlay
//   Draws a disc, ring or disc+crosshair marker centred on the detected
//   centroid over an RGB stream. Marker settings are frozen on each vsync
//   rising edge. Pixel data and syncs leave exactly PIPE_LAT (3) clocks later.
//   Ports: clk, rst (async, active high), vid (slave side of the
//   centroid_marker_overlay_if bundle).
// -----------------------------------------------------------------------------
module centroid_marker_overlay
    import centroid_marker_overlay_pkg::*;
#(
    parameter int unsigned IMG_W      = 64,
    parameter int unsigned IMG_H      = 64,
    parameter int unsigned MAX_RADIUS = 31,
    parameter int unsigned RING_W     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    centroid_marker_overlay_if.slave vid
);

    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(IMG_H - 1);
    localparam logic [RAD_W-1:0]   R_MAX = RAD_W'(MAX_RADIUS);
    localparam logic [RAD_W-1:0]   RING  = RAD_W'(RING_W);

    // ---------------- edge detect and position counters ----------------
    logic de_prev_q, vs_prev_q;
    logic vs_rise, de_fall;
    logic [COORD_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [COORD_W-1:0] cur_x, cur_y;

    assign vs_rise = vid.vsync & ~vs_prev_q;
    assign de_fall = de_prev_q & ~vid.de;

    // A pixel arriving with the vsync rise is (0,0) of the new frame, so the
    // counter reset is applied combinationally to the current position too.
    always_comb begin
        cur_x   = vs_rise ? '0 : pos_x_q;
        cur_y   = vs_rise ? '0 : pos_y_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        if (vs_rise) begin
            pos_x_d = vid.de ? COORD_W'(1) : '0;
            pos_y_d = '0;
        end else if (vid.de) begin
            pos_x_d = (pos_x_q == X_MAX) ? X_MAX : pos_x_q + 1'b1;
        end else if (de_fall) begin
            pos_x_d = '0;
            pos_y_d = (pos_y_q == Y_MAX) ? Y_MAX : pos_y_q + 1'b1;
        end
    end

    // ---------------- per-frame shadow registers ----------------
    logic [COORD_W-1:0] cx_q, cy_q, cx_eff, cy_eff;
    marker_cfg_t        cfg_q, cfg_eff;

    // The new frame's settings already apply to a pixel coincident with vsync rise.
    always_comb begin
        cx_eff        = cx_q;
        cy_eff        = cy_q;
        cfg_eff       = cfg_q;
        if (vs_rise) begin
            cx_eff        = vid.x;
            cy_eff        = vid.y;
            cfg_eff.valid = vid.c_valid;
            cfg_eff.mode  = mode_e'(vid.mode);
            cfg_eff.r     = clamp_radius(vid.radius, R_MAX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
            pos_x_q   <= '0;
            pos_y_q   <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            cfg_q     <= '0;
        end else begin
            de_prev_q <= vid.de;
            vs_prev_q <= vid.vsync;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            cx_q      <= cx_eff;
            cy_q      <= cy_eff;
            cfg_q     <= cfg_eff;
        end
    end

    // ---------------- S1/S2: distance per axis ----------------
    logic signed [DIFF_W-1:0] dx_s1, dy_s1;
    logic [SQ_W-1:0]          sqx_s2, sqy_s2;

    dist2_unit u_dist_x (
        .clk   (clk),
        .rst   (rst),
        .pos_i (cur_x),
        .c_i   (cx_eff),
        .d_o   (dx_s1),
        .sq_o  (sqx_s2)
    );

    dist2_unit u_dist_y (
        .clk   (clk),
        .rst   (rst),
        .pos_i (cur_y),
        .c_i   (cy_eff),
        .d_o   (dy_s1),
        .sq_o  (sqy_s2)
    );

    // Stream and settings travel alongside the distance datapath so that
    // each pixel is judged with the settings in force when it arrived.
    logic [RGB_W-1:0] pix_s1_q, pix_s2_q, col_s1_q, col_s2_q;
    logic [2:0]       sync_s1_q, sync_s2_q;   // {de, hsync, vsync}
    marker_cfg_t      cfg_s1_q, cfg_s2_q;
    logic             eqx_s2_q, eqy_s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_s1_q  <= '0;
            pix_s2_q  <= '0;
            col_s1_q  <= '0;
            col_s2_q  <= '0;
            sync_s1_q <= '0;
            sync_s2_q <= '0;
            cfg_s1_q  <= '0;
            cfg_s2_q  <= '0;
            eqx_s2_q  <= 1'b0;
            eqy_s2_q  <= 1'b0;
        end else begin
            pix_s1_q  <= vid.pixel_in;
            col_s1_q  <= vid.color;
            sync_s1_q <= {vid.de, vid.hsync, vid.vsync};
            cfg_s1_q  <= cfg_eff;
            pix_s2_q  <= pix_s1_q;
            col_s2_q  <= col_s1_q;
            sync_s2_q <= sync_s1_q;
            cfg_s2_q  <= cfg_s1_q;
            eqx_s2_q  <= (dx_s1 == '0);
            eqy_s2_q  <= (dy_s1 == '0);
        end
    end

    // ---------------- S3: hit test and output mux ----------------
    logic [D2_W-1:0]  d2;
    logic [R2_W-1:0]  r2, ri2;
    logic [RAD_W-1:0] ri;
    logic             in_disc, outside_inner, hit;
    logic [RGB_W-1:0] pix_out_d, pix_out_q;
    logic [2:0]       sync_out_q;

    always_comb begin
        d2            = D2_W'(sqx_s2) + D2_W'(sqy_s2);
        r2            = R2_W'(cfg_s2_q.r) * R2_W'(cfg_s2_q.r);
        ri            = (cfg_s2_q.r > RING) ? cfg_s2_q.r - RING : '0;
        ri2           = R2_W'(ri) * R2_W'(ri);
        in_disc       = (d2 <= D2_W'(r2));
        outside_inner = (d2 >= D2_W'(ri2));
        hit           = 1'b0;
        if (cfg_s2_q.valid) begin
            unique case (cfg_s2_q.mode)
                MODE_DISC:       hit = in_disc;
                MODE_RING:       hit = in_disc & outside_inner;
                MODE_DISC_CROSS: hit = in_disc | eqx_s2_q | eqy_s2_q;
                default:         hit = 1'b0;
            endcase
        end
        pix_out_d = (hit & sync_s2_q[2]) ? col_s2_q : pix_s2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_out_q  <= '0;
            sync_out_q <= '0;
        end else begin
            pix_out_q  <= pix_out_d;
            sync_out_q <= sync_s2_q;
        end
    end

    assign vid.pixel_out = pix_out_q;
    assign vid.de_out    = sync_out_q[2];
    assign vid.hsync_out = sync_out_q[1];
    assign vid.vsync_out = sync_out_q[0];

endmodule

// File: tb/tb_centroid_marker_overlay.sv
// -----------------------------------------------------------------------------
// tb_centroid_marker_overlay
//   Directed frames plus a short random stream; a frame-level model predicts
//   every output cycle, and literal pixel expectations pin specific markers.
// -----------------------------------------------------------------------------
module tb_centroid_marker_overlay;
    import centroid_marker_overlay_pkg::*;

    localparam logic [23:0] RED   = 24'hFF0000;
    localparam logic [23:0] GREEN = 24'h00FF00;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    centroid_marker_overlay_if vid();

    centroid_marker_overlay #(
        .IMG_W      (64),
        .IMG_H      (64),
        .MAX_RADIUS (31),
        .RING_W     (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .vid (vid)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    typedef struct {
        logic [23:0] pix;
        logic        de, hs, vs;
        int          x, y;
    } exp_t;

    exp_t        expq[$];
    logic [23:0] fb    [64][64];
    logic [23:0] inbuf [64][64];

    int   m_col, m_row;
    logic m_prev_de, m_prev_vs;
    logic sh_valid;
    int   sh_cx, sh_cy, sh_r;
    logic [1:0] sh_mode;

    function automatic bit marker_hit(input int px, input int py);
        int  dx, dy, d2, ri;
        bit  disc;
        dx   = px - sh_cx;
        dy   = py - sh_cy;
        d2   = dx * dx + dy * dy;
        ri   = (sh_r > 2) ? sh_r - 2 : 0;
        disc = (d2 <= sh_r * sh_r);
        if (!sh_valid) return 1'b0;
        case (sh_mode)
            2'd1:    return disc;
            2'd2:    return disc && (d2 >= ri * ri);
            2'd3:    return disc || (px == sh_cx) || (py == sh_cy);
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        exp_t e;
        bit   rise, fall;
        if (rst) begin
            m_col = 0; m_row = 0; m_prev_de = 0; m_prev_vs = 0;
            sh_valid = 0; sh_cx = 0; sh_cy = 0; sh_r = 0; sh_mode = 2'd0;
            expq.delete();
        end else begin
            rise = vid.vsync && !m_prev_vs;
            fall = m_prev_de && !vid.de;
            if (rise) begin
                m_col = 0; m_row = 0;
                sh_valid = vid.c_valid;
                sh_cx    = int'(vid.x);
                sh_cy    = int'(vid.y);
                sh_r     = (vid.radius > 6'd31) ? 31 : int'(vid.radius);
                sh_mode  = vid.mode;
            end else if (fall) begin
                m_col = 0;
                m_row = (m_row < 63) ? m_row + 1 : 63;
            end
            e.x   = m_col;
            e.y   = m_row;
            e.de  = vid.de;
            e.hs  = vid.hsync;
            e.vs  = vid.vsync;
            e.pix = (vid.de && marker_hit(m_col, m_row)) ? vid.color : vid.pixel_in;
            if (vid.de) begin
                inbuf[m_row][m_col] = vid.pixel_in;
                m_col = (m_col < 63) ? m_col + 1 : 63;
            end
            m_prev_de = vid.de;
            m_prev_vs = vid.vsync;
            expq.push_back(e);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst || expq.size() < PIPE_LAT) begin
            check("idle_pix", vid.pixel_out, 24'h0);
            check("idle_sync", {21'b0, vid.de_out, vid.hsync_out, vid.vsync_out}, 24'h0);
        end else begin
            e = expq.pop_front();
            check("pix", vid.pixel_out, e.pix);
            check("sync", {21'b0, vid.de_out, vid.hsync_out, vid.vsync_out},
                  {21'b0, e.de, e.hs, e.vs});
            if (e.de) fb[e.y][e.x] = vid.pixel_out;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fb();
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++)
                fb[r][c] = 24'h0;
    endtask

    task automatic set_cfg(input int cx, input int cy, input bit v, input int r,
                           input logic [1:0] m, input logic [23:0] col);
        vid.x       = 12'(cx);
        vid.y       = 12'(cy);
        vid.c_valid = v;
        vid.radius  = 6'(r);
        vid.mode    = m;
        vid.color   = col;
    endtask

    // One 64x64 frame. chg_line: line at whose start x becomes chg_x.
    // rst_line: line at whose start reset is pulsed.
    task automatic frame(input int chg_line, input logic [11:0] chg_x, input int rst_line);
        clear_fb();
        vid.de = 0; vid.hsync = 0;
        vid.vsync = 1; tick(); tick();
        vid.vsync = 0; tick();
        for (int l = 0; l < 64; l++) begin
            if (l == chg_line) vid.x = chg_x;
            if (l == rst_line) begin
                rst = 1;
                #1;
                check("rst_pix_now", vid.pixel_out, 24'h0);
                check("rst_sync_now", {21'b0, vid.de_out, vid.hsync_out, vid.vsync_out}, 24'h0);
                tick(); tick();
                rst = 0;
                clear_fb();
            end
            vid.hsync = 1; tick();
            vid.hsync = 0; tick();
            for (int c = 0; c < 64; c++) begin
                vid.de       = 1;
                vid.pixel_in = {1'b0, 23'($urandom)};
                tick();
            end
            vid.de = 0; tick();
        end
        repeat (4) tick();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        rst = 0;
        vid.de = 0; vid.hsync = 0; vid.vsync = 0; vid.pixel_in = '0;
        set_cfg(0, 0, 0, 0, 2'd0, 24'h0);
        #1 rst = 1;
        repeat (3) tick();
        rst = 0;
        tick();

        // Disc r=5 at (32,32)
        set_cfg(32, 32, 1, 5, 2'd1, RED);
        frame(-1, 12'd0, -1);
        check("t1_32_27",  fb[27][32], RED);
        check("t1_37_32",  fb[32][37], RED);
        check("t1_36_36",  fb[36][36], inbuf[36][36]);
        check("t1_38_32",  fb[32][38], inbuf[32][38]);

        // Ring r=6
        set_cfg(32, 32, 1, 6, 2'd2, RED);
        frame(-1, 12'd0, -1);
        check("t2_32_26",  fb[26][32], RED);
        check("t2_36_32",  fb[32][36], RED);
        check("t2_32_32",  fb[32][32], inbuf[32][32]);
        check("t2_33_32",  fb[32][33], inbuf[32][33]);
        check("t2_32_25",  fb[25][32], inbuf[25][32]);

        // Disc + cross at the bottom-left corner
        set_cfg(0, 63, 1, 3, 2'd3, GREEN);
        frame(-1, 12'd0, -1);
        for (int i = 0; i < 64; i++) begin
            check("t3_row63", fb[63][i], GREEN);
            check("t3_col0",  fb[i][0],  GREEN);
        end
        check("t3_1_62",  fb[62][1],  GREEN);
        check("t3_2_61",  fb[61][2],  GREEN);
        check("t3_3_61",  fb[61][3],  inbuf[61][3]);
        check("t3_63_0",  fb[0][63],  inbuf[0][63]);
        check("t3_63_62", fb[62][63], inbuf[62][63]);

        // Mid-frame centroid change takes effect next frame
        set_cfg(10, 32, 1, 5, 2'd1, RED);
        frame(5, 12'd40, -1);
        check("t4a_10_32", fb[32][10], RED);
        check("t4a_40_32", fb[32][40], inbuf[32][40]);
        frame(-1, 12'd0, -1);
        check("t4b_40_32", fb[32][40], RED);
        check("t4b_10_32", fb[32][10], inbuf[32][10]);
        vid.c_valid = 0;
        frame(-1, 12'd0, -1);
        check("t4c_40_32", fb[32][40], inbuf[32][40]);

        // Random stream, marker off
        set_cfg(20, 20, 1, 10, 2'd0, RED);
        for (int i = 0; i < 400; i++) begin
            vid.de       = 1'($urandom_range(0, 1));
            vid.hsync    = 1'($urandom_range(0, 1));
            vid.vsync    = ($urandom_range(0, 15) == 0);
            vid.pixel_in = 24'($urandom);
            tick();
        end
        vid.de = 0; vid.hsync = 0; vid.vsync = 0;
        repeat (4) tick();

        // Reset mid-frame, then clamped radius
        set_cfg(32, 32, 1, 50, 2'd1, RED);
        frame(-1, 12'd0, 20);
        n = 0;
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++)
                if (fb[r][c] == RED) n++;
        check("t6_no_marker_after_rst", 24'(n), 24'h0);
        frame(-1, 12'd0, -1);
        check("t6_32_1",  fb[1][32],  RED);
        check("t6_32_0",  fb[0][32],  inbuf[0][32]);
        check("t6_63_32", fb[32][63], RED);
        check("t6_0_32",  fb[32][0],  inbuf[32][0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
